// File: rtl/maxpool1d.sv
// Streaming 1D max-pooling stage: reduces each non-overlapping window of
// POOL_SIZE signed samples to its maximum over a valid/ready interface.
module maxpool1d #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned POOL_SIZE  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  maxpool_ready_in,
    input  logic                  maxpool_valid_in,
    input  logic [DATA_WIDTH-1:0] maxpool_data_in,
    input  logic                  maxpool_ready_out,
    output logic                  maxpool_valid_out,
    output logic [DATA_WIDTH-1:0] maxpool_data_out
);

    localparam int unsigned      CNT_W    = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_SIZE - 1);

    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] run_max;
    logic [DATA_WIDTH-1:0] win_max;
    logic                  last;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  close;

    // Handshake decode and running-max candidate including the current sample
    always_comb begin
        last             = (cnt == CNT_LAST);
        maxpool_ready_in = !last || !maxpool_valid_out || maxpool_ready_out;
        in_xfer          = maxpool_valid_in && maxpool_ready_in;
        out_xfer         = maxpool_valid_out && maxpool_ready_out;
        close            = in_xfer && last;
        win_max          = maxpool_data_in;
        if ((cnt != '0) && ($signed(run_max) > $signed(maxpool_data_in))) begin
            win_max = run_max;
        end
    end

    // Window position and partial maximum; only move on an accepted sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            run_max <= '0;
        end else if (in_xfer) begin
            cnt     <= last ? '0 : cnt + CNT_W'(1);
            run_max <= win_max;
        end
    end

    // Output slot: a closing window overwrites a draining result with no bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            maxpool_valid_out <= 1'b0;
            maxpool_data_out  <= '0;
        end else if (close) begin
            maxpool_valid_out <= 1'b1;
            maxpool_data_out  <= win_max;
        end else if (out_xfer) begin
            maxpool_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maxpool1d.sv
// Directed self-checking bench for maxpool1d with POOL_SIZE of 2, 3 and 1.
module tb_maxpool1d;

    logic clk;
    logic rst;

    logic        ri2, v2, ro2, vo2;
    logic [11:0] d2, do2;
    logic        ri3, v3, ro3, vo3;
    logic [11:0] d3, do3;
    logic        ri1, v1, ro1, vo1;
    logic [11:0] d1, do1;

    int tests = 0;
    int fails = 0;

    maxpool1d #(.DATA_WIDTH(12), .POOL_SIZE(2)) u2 (
        .clk(clk), .rst(rst),
        .maxpool_ready_in(ri2), .maxpool_valid_in(v2), .maxpool_data_in(d2),
        .maxpool_ready_out(ro2), .maxpool_valid_out(vo2), .maxpool_data_out(do2)
    );

    maxpool1d #(.DATA_WIDTH(12), .POOL_SIZE(3)) u3 (
        .clk(clk), .rst(rst),
        .maxpool_ready_in(ri3), .maxpool_valid_in(v3), .maxpool_data_in(d3),
        .maxpool_ready_out(ro3), .maxpool_valid_out(vo3), .maxpool_data_out(do3)
    );

    maxpool1d #(.DATA_WIDTH(12), .POOL_SIZE(1)) u1 (
        .clk(clk), .rst(rst),
        .maxpool_ready_in(ri1), .maxpool_valid_in(v1), .maxpool_data_in(d1),
        .maxpool_ready_out(ro1), .maxpool_valid_out(vo1), .maxpool_data_out(do1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] s3 [9];
    logic [11:0] e3 [3];
    logic [11:0] s1 [4];
    logic [11:0] exp_do;
    logic        exp_ri;
    int          idx;

    initial begin
        s3 = '{12'd1, 12'd2, 12'd3, 12'd6, 12'd5, 12'd4, 12'hFF9, 12'hFF8, 12'hFF7};
        e3 = '{12'd3, 12'd6, 12'hFF9};
        s1 = '{12'd100, 12'hFFD, 12'd0, 12'h800};

        rst = 1'b0;
        v2 = 0; d2 = '0; ro2 = 0;
        v3 = 0; d3 = '0; ro3 = 0;
        v1 = 0; d1 = '0; ro1 = 0;
        #1;
        chk("reset_vo2", 32'(vo2), 32'd0);
        chk("reset_do2", 32'(do2), 32'd0);
        chk("reset_ri2", 32'(ri2), 32'd1);
        chk("reset_vo3", 32'(vo3), 32'd0);
        chk("reset_vo1", 32'(vo1), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // Basic windows
        ro2 = 1; v2 = 1; d2 = 12'd5; #1;
        chk("t1_ri_s0", 32'(ri2), 32'd1);
        cyc();
        chk("t1_vo_after5", 32'(vo2), 32'd0);
        d2 = 12'd3; #1;
        chk("t1_ri_s1", 32'(ri2), 32'd1);
        cyc();
        chk("t1_vo_w0", 32'(vo2), 32'd1);
        chk("t1_do_w0", 32'(do2), 32'd5);
        d2 = 12'hFFE; #1;
        chk("t1_ri_s2", 32'(ri2), 32'd1);
        cyc();
        chk("t1_vo_drain", 32'(vo2), 32'd0);
        d2 = 12'd7; #1;
        chk("t1_ri_s3", 32'(ri2), 32'd1);
        cyc();
        chk("t1_vo_w1", 32'(vo2), 32'd1);
        chk("t1_do_w1", 32'(do2), 32'd7);
        v2 = 0; cyc();
        chk("t1_vo_idle", 32'(vo2), 32'd0);

        // Signed comparison at the extremes
        v2 = 1; d2 = 12'hFFC; cyc();
        d2 = 12'hFFF; cyc();
        chk("t2_vo_a", 32'(vo2), 32'd1);
        chk("t2_do_a", 32'(do2), 32'hFFF);
        d2 = 12'h7FF; cyc();
        d2 = 12'h800; cyc();
        chk("t2_vo_b", 32'(vo2), 32'd1);
        chk("t2_do_b", 32'(do2), 32'h7FF);
        v2 = 0; cyc();

        // Backpressure
        ro2 = 0; v2 = 1; d2 = 12'd5; cyc();
        d2 = 12'd0; cyc();
        chk("t3_vo_held", 32'(vo2), 32'd1);
        chk("t3_do_held", 32'(do2), 32'd5);
        d2 = 12'd1; #1;
        chk("t3_ri_nonfinal", 32'(ri2), 32'd1);
        cyc();
        d2 = 12'd9; #1;
        chk("t3_ri_stall", 32'(ri2), 32'd0);
        cyc();
        chk("t3_do_stall", 32'(do2), 32'd5);
        chk("t3_vo_stall", 32'(vo2), 32'd1);
        ro2 = 1; #1;
        chk("t3_ri_release", 32'(ri2), 32'd1);
        cyc();
        chk("t3_vo_replace", 32'(vo2), 32'd1);
        chk("t3_do_replace", 32'(do2), 32'd9);
        v2 = 0; cyc();
        chk("t3_vo_drain", 32'(vo2), 32'd0);

        // Full throughput with POOL_SIZE=3
        ro3 = 1; v3 = 1;
        for (int i = 0; i < 9; i++) begin
            d3 = s3[i]; #1;
            chk("t4_ri", 32'(ri3), 32'd1);
            cyc();
            chk("t4_vo", 32'(vo3), (i % 3 == 2) ? 32'd1 : 32'd0);
            if (i % 3 == 2) chk("t4_do", 32'(do3), 32'(e3[i / 3]));
        end
        v3 = 0;

        // Asynchronous reset mid-operation
        ro2 = 0; v2 = 1; d2 = 12'd6; cyc();
        d2 = 12'd4; cyc();
        chk("t5_do_pre", 32'(do2), 32'd6);
        d2 = 12'd8; cyc();
        v2 = 0; #2;
        rst = 1'b0; #1;
        chk("t5_vo_async", 32'(vo2), 32'd0);
        chk("t5_do_async", 32'(do2), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        ro2 = 1; v2 = 1; d2 = 12'd1; cyc();
        chk("t5_vo_first", 32'(vo2), 32'd0);
        d2 = 12'd2; cyc();
        chk("t5_vo_out", 32'(vo2), 32'd1);
        chk("t5_do_out", 32'(do2), 32'd2);
        v2 = 0; cyc();

        // POOL_SIZE=1 with toggling ready_out
        idx = 0; exp_do = '0; v1 = 1;
        for (int k = 0; k < 8; k++) begin
            ro1 = (k % 2 == 0);
            d1 = s1[idx]; #1;
            exp_ri = (k == 0) ? 1'b1 : ro1;
            chk("t6_ri", 32'(ri1), 32'(exp_ri));
            cyc();
            if (exp_ri) begin
                exp_do = s1[idx];
                idx++;
            end
            chk("t6_vo", 32'(vo1), 32'd1);
            chk("t6_do", 32'(do1), 32'(exp_do));
        end
        v1 = 0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
